conv_tap_feeder: RTL and testbench

- Upstream stage of the convolution accumulator.
- Holds one TAPS-element window of pixel/coefficient pairs, loaded serially.
- On Start, streams the signed products pixel×coef, one per cycle, over a valid/ready handshake into the 32-bit accumulator input.
- Flags the last product of the window and pulses Done once the whole window has been consumed.

---
 rtl/conv_pkg.sv | 19 +
 rtl/conv_tap_buffer.sv | 27 ++
 rtl/conv_tap_feeder.sv | 134 +++++++++++++
 tb/tb_conv_tap_feeder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and constants for the convolution tap feeder
package conv_pkg;

  localparam int DATA_W       = 16;
  localparam int PROD_W       = 2 * DATA_W;
  localparam int TAPS_DEFAULT = 9;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic signed [DATA_W-1:0] pix;
    logic signed [DATA_W-1:0] coef;
  } tap_entry_t;

endpackage

// File: rtl/conv_tap_buffer.sv
// rtl/conv_tap_buffer.sv - TAPS-deep pixel/coef register array, one write port, async read port
module conv_tap_buffer
  import conv_pkg::*;
#(
  parameter int TAPS  = TAPS_DEFAULT,
  parameter int IDX_W = 4
) (
  input  logic             Clk,
  input  logic             WrEn,
  input  logic [IDX_W-1:0] WrIdx,
  input  tap_entry_t       WrData,
  input  logic [IDX_W-1:0] RdIdx,
  output tap_entry_t       RdData
);

  // Contents are don't-care after reset, so the array carries no reset.
  tap_entry_t mem [TAPS];

  always_ff @(posedge Clk) begin
    if (WrEn) begin
      mem[WrIdx] <= WrData;
    end
  end

  assign RdData = mem[RdIdx];

endmodule

// File: rtl/conv_tap_feeder.sv
// rtl/conv_tap_feeder.sv - loads a pixel/coef window, then streams signed products with valid/ready
module conv_tap_feeder #(
  parameter  int TAPS   = conv_pkg::TAPS_DEFAULT,
  parameter  int DATA_W = conv_pkg::DATA_W,
  localparam int PROD_W = 2 * DATA_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              LoadEn,
  input  logic [DATA_W-1:0] LoadPix,
  input  logic [DATA_W-1:0] LoadCoef,
  output logic              Full,
  input  logic              Start,
  output logic              Busy,
  output logic [PROD_W-1:0] ProdOut,
  output logic              ProdValid,
  input  logic              ProdReady,
  output logic              ProdLast,
  output logic              Done
);
  import conv_pkg::*;

  localparam int               IDX_W    = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

  state_t                   state, stateNext;
  logic [IDX_W-1:0]         loadIdx, tapIdx;
  logic                     full, busy, prodValid, prodLast, done;
  logic [PROD_W-1:0]        prodOut;
  logic                     bufWrEn, startAccept, advance, finish;
  tap_entry_t               wrEntry, rdEntry;
  logic signed [PROD_W-1:0] pixExt, coefExt, product;

  assign wrEntry = '{pix: LoadPix, coef: LoadCoef};

  conv_tap_buffer #(
    .TAPS  (TAPS),
    .IDX_W (IDX_W)
  ) uTapBuffer (
    .Clk    (Clk),
    .WrEn   (bufWrEn),
    .WrIdx  (loadIdx),
    .WrData (wrEntry),
    .RdIdx  (tapIdx),
    .RdData (rdEntry)
  );

  // Sign-extend before multiplying so the full-width product is exact.
  assign pixExt  = PROD_W'(signed'(rdEntry.pix));
  assign coefExt = PROD_W'(signed'(rdEntry.coef));
  assign product = pixExt * coefExt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (startAccept)                   stateNext = RUN;
      RUN:     if (advance && tapIdx == LAST_IDX) stateNext = DRAIN;
      DRAIN:   if (finish)                        stateNext = IDLE;
      default:                                    stateNext = IDLE;
    endcase
  end

  // Start is judged against the registered Full, i.e. before a same-cycle write lands.
  always_comb begin
    bufWrEn     = 1'b0;
    startAccept = 1'b0;
    advance     = 1'b0;
    finish      = 1'b0;
    case (state)
      IDLE: begin
        bufWrEn     = LoadEn;
        startAccept = Start && full;
      end
      RUN:     advance = !prodValid || ProdReady;
      DRAIN:   finish  = prodValid && ProdReady && prodLast;
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      loadIdx   <= '0;
      tapIdx    <= '0;
      full      <= 1'b0;
      busy      <= 1'b0;
      prodOut   <= '0;
      prodValid <= 1'b0;
      prodLast  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bufWrEn) begin
        loadIdx <= (loadIdx == LAST_IDX) ? '0 : loadIdx + IDX_W'(1);
        if (loadIdx == LAST_IDX) begin
          full <= 1'b1;
        end
      end
      if (startAccept) begin
        busy   <= 1'b1;
        tapIdx <= '0;
      end
      if (advance) begin
        prodOut   <= product;
        prodValid <= 1'b1;
        prodLast  <= (tapIdx == LAST_IDX);
        tapIdx    <= (tapIdx == LAST_IDX) ? '0 : tapIdx + IDX_W'(1);
      end
      if (finish) begin
        prodValid <= 1'b0;
        prodLast  <= 1'b0;
        done      <= 1'b1;
        busy      <= 1'b0;
        full      <= 1'b0;
        loadIdx   <= '0;
      end
    end
  end

  assign Full      = full;
  assign Busy      = busy;
  assign ProdOut   = prodOut;
  assign ProdValid = prodValid;
  assign ProdLast  = prodLast;
  assign Done      = done;

endmodule

// File: tb/tb_conv_tap_feeder.sv
// tb/tb_conv_tap_feeder.sv - directed self-checking bench for conv_tap_feeder
module tb_conv_tap_feeder;

  localparam int TAPS_N = 9;

  logic        Clk = 1'b0;
  logic        Reset, LoadEn, Start, ProdReady;
  logic [15:0] LoadPix, LoadCoef;
  logic        Full, Busy, ProdValid, ProdLast, Done;
  logic [31:0] ProdOut;

  logic [31:0] expProd [TAPS_N];
  int          checkCount = 0;
  int          passCount  = 0;

  conv_tap_feeder #(.TAPS(TAPS_N), .DATA_W(16)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .LoadEn    (LoadEn),
    .LoadPix   (LoadPix),
    .LoadCoef  (LoadCoef),
    .Full      (Full),
    .Start     (Start),
    .Busy      (Busy),
    .ProdOut   (ProdOut),
    .ProdValid (ProdValid),
    .ProdReady (ProdReady),
    .ProdLast  (ProdLast),
    .Done      (Done)
  );

  always #5 Clk = ~Clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
  endtask

  task automatic loadPair(input logic [15:0] pix, input logic [15:0] coef);
    LoadEn   = 1'b1;
    LoadPix  = pix;
    LoadCoef = coef;
    @(negedge Clk);
    LoadEn   = 1'b0;
  endtask

  // mode 0: ProdReady held high; mode 1: ProdReady pattern 1,0,0 repeating
  task automatic runWindow(input int mode);
    int          got, lastCyc;
    bit          stalled, doneSeen;
    logic [31:0] heldVal;
    logic        ready;
    got = 0; lastCyc = -10; stalled = 0; doneSeen = 0; heldVal = '0;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    checkVal("busyRise", 32'(Busy), 32'd1);
    checkVal("validLatency", 32'(ProdValid), 32'd0);
    for (int cyc = 1; cyc <= 60 && !doneSeen; cyc++) begin
      @(negedge Clk);
      ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 1);
      if (stalled) begin
        checkVal("holdOut", ProdOut, heldVal);
        checkVal("holdValid", 32'(ProdValid), 32'd1);
      end
      if (mode == 0 && got < TAPS_N) checkVal("streamValid", 32'(ProdValid), 32'd1);
      if (Done) begin
        checkVal("doneTiming", 32'(cyc), 32'(lastCyc + 1));
        checkVal("doneXfers", 32'(got), 32'(TAPS_N));
        checkVal("doneBusy", 32'(Busy), 32'd0);
        checkVal("doneValid", 32'(ProdValid), 32'd0);
        checkVal("doneFull", 32'(Full), 32'd0);
        doneSeen = 1;
      end
      ProdReady = ready;
      if (ProdValid && ready) begin
        if (got < TAPS_N) begin
          checkVal("prod", ProdOut, expProd[got]);
          checkVal("last", 32'(ProdLast), 32'(got == TAPS_N - 1));
        end else begin
          checkVal("extraXfer", 32'(got), 32'(TAPS_N - 1));
        end
        got++;
        if (got == TAPS_N) lastCyc = cyc;
      end
      stalled = ProdValid && !ready;
      heldVal = ProdOut;
    end
    ProdReady = 1'b0;
    checkVal("doneSeen", 32'(doneSeen), 32'd1);
    @(negedge Clk);
    checkVal("donePulse", 32'(Done), 32'd0);
  endtask

  task automatic setExpCoef2();
    for (int i = 0; i < TAPS_N; i++) expProd[i] = 32'(2 * (i + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    bit found;
    Reset = 1'b1; LoadEn = 1'b0; Start = 1'b0; ProdReady = 1'b0;
    LoadPix = '0; LoadCoef = '0;
    @(negedge Clk);
    @(negedge Clk);
    checkVal("rstBusy", 32'(Busy), 32'd0);
    checkVal("rstValid", 32'(ProdValid), 32'd0);
    checkVal("rstFull", 32'(Full), 32'd0);
    checkVal("rstDone", 32'(Done), 32'd0);
    checkVal("rstLast", 32'(ProdLast), 32'd0);
    checkVal("rstProd", ProdOut, 32'd0);
    Reset = 1'b0;

    // basic window: pix=i+1, coef=2
    for (int i = 0; i < TAPS_N; i++) loadPair(16'(i + 1), 16'd2);
    checkVal("fullAfter9", 32'(Full), 32'd1);
    setExpCoef2();
    runWindow(0);

    // most negative squared
    for (int i = 0; i < TAPS_N; i++) loadPair(16'h8000, 16'h8000);
    for (int i = 0; i < TAPS_N; i++) expProd[i] = 32'h4000_0000;
    runWindow(0);

    // -3 * 7
    for (int i = 0; i < TAPS_N; i++) loadPair(16'hFFFD, 16'd7);
    for (int i = 0; i < TAPS_N; i++) expProd[i] = 32'hFFFF_FFEB;
    runWindow(0);

    // backpressure
    for (int i = 0; i < TAPS_N; i++) loadPair(16'(i + 1), 16'd2);
    setExpCoef2();
    runWindow(1);

    // partial load, Start ignored, same-cycle load+start, wrap overwrite
    for (int i = 0; i < 5; i++) loadPair(16'(i + 1), 16'(i + 1));
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    checkVal("partialBusy", 32'(Busy), 32'd0);
    @(negedge Clk);
    checkVal("partialValid", 32'(ProdValid), 32'd0);
    checkVal("partialFull", 32'(Full), 32'd0);
    for (int i = 5; i < 8; i++) loadPair(16'(i + 1), 16'(i + 1));
    Start = 1'b1;
    loadPair(16'd9, 16'd9);
    Start = 1'b0;
    checkVal("sameCycFull", 32'(Full), 32'd1);
    checkVal("sameCycBusy", 32'(Busy), 32'd0);
    @(negedge Clk);
    checkVal("sameCycIdle", 32'(Busy), 32'd0);
    loadPair(16'd100, 16'd3);
    checkVal("fullWrap", 32'(Full), 32'd1);
    expProd[0] = 32'd300;
    for (int i = 1; i < TAPS_N; i++) expProd[i] = 32'((i + 1) * (i + 1));
    runWindow(0);

    // reset at the 4th product
    for (int i = 0; i < TAPS_N; i++) loadPair(16'(i + 1), 16'd2);
    ProdReady = 1'b1;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    found = 0;
    for (int cyc = 0; cyc < 10 && !found; cyc++) begin
      @(negedge Clk);
      if (ProdValid && ProdOut == 32'd8) found = 1;
    end
    checkVal("reached4th", 32'(found), 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    checkVal("midRstProd", ProdOut, 32'd0);
    checkVal("midRstValid", 32'(ProdValid), 32'd0);
    checkVal("midRstLast", 32'(ProdLast), 32'd0);
    checkVal("midRstBusy", 32'(Busy), 32'd0);
    checkVal("midRstFull", 32'(Full), 32'd0);
    checkVal("midRstDone", 32'(Done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      checkVal("postRstDone", 32'(Done), 32'd0);
      checkVal("postRstValid", 32'(ProdValid), 32'd0);
    end
    ProdReady = 1'b0;
    for (int i = 0; i < TAPS_N; i++) loadPair(16'(i + 1), 16'd2);
    setExpCoef2();
    runWindow(0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
